// File: rtl/cmp_seq_pkg.sv
// Shared definitions for the serial compare sequencer and its comparator core.
package cmp_seq_pkg;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One-hot result codes, ordered {L, E, G}
    localparam logic [2:0] RES_L = 3'b100;
    localparam logic [2:0] RES_E = 3'b010;
    localparam logic [2:0] RES_G = 3'b001;

endpackage

// File: rtl/bit_serial_cmp_core.sv
// Bit-serial unsigned comparator core: the first differing bit pair decides
// the result, which stays sticky until the next clear.
module bit_serial_cmp_core (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic a,
    input  logic b,
    output logic decided,
    output logic lt,
    output logic gt
);

    logic decided_q, decided_d;
    logic lt_q, lt_d;
    logic gt_q, gt_d;

    // Next decision: clear wins, otherwise latch only the first difference seen
    always_comb begin
        decided_d = decided_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        if (clr) begin
            decided_d = 1'b0;
            lt_d      = 1'b0;
            gt_d      = 1'b0;
        end else if (bit_en && !decided_q && (a != b)) begin
            decided_d = 1'b1;
            lt_d      = b;
            gt_d      = a;
        end
    end

    // Decision registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            decided_q <= decided_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
        end
    end

    assign decided = decided_q;
    assign lt      = lt_q;
    assign gt      = gt_q;

endmodule

// File: rtl/serial_compare_sequencer.sv
// Captures two parallel operands and streams them MSB-first through the
// bit-serial comparator, publishing held L/E/G flags and a done pulse.
module serial_compare_sequencer
    import cmp_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       busy,
    output logic                       done,
    output logic                       L,
    output logic                       E,
    output logic                       G,
    output logic [$clog2(WIDTH+1)-1:0] bits_used
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      res_q, res_d;
    logic [CW-1:0]   bits_used_q, bits_used_d;

    logic            core_clr;
    logic            core_bit_en;
    logic            core_decided;
    logic            core_lt;
    logic            core_gt;
    logic            diff_now;
    logic [2:0]      res_now;
    logic [CW-1:0]   consumed_now;

    bit_serial_cmp_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .bit_en  (core_bit_en),
        .a       (sa_q[WIDTH-1]),
        .b       (sb_q[WIDTH-1]),
        .decided (core_decided),
        .lt      (core_lt),
        .gt      (core_gt)
    );

    // Result as it would stand after consuming the bit currently at the MSB
    always_comb begin
        diff_now     = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];
        consumed_now = WIDTH_C - cnt_q + CW'(1);
        res_now      = RES_E;
        if (core_decided) begin
            res_now = core_gt ? RES_G : (core_lt ? RES_L : RES_E);
        end else if (diff_now) begin
            res_now = sa_q[WIDTH-1] ? RES_G : RES_L;
        end
    end

    // FSM next-state, datapath updates and result publication
    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_d       = res_q;
        bits_used_d = bits_used_q;
        core_clr    = 1'b0;
        core_bit_en = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    sa_d     = a_in;
                    sb_d     = b_in;
                    cnt_d    = WIDTH_C;
                    core_clr = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    core_bit_en = 1'b1;
                    sa_d        = sa_q << 1;
                    sb_d        = sb_q << 1;
                    cnt_d       = cnt_q - CW'(1);
                    if ((cnt_q == CW'(1)) ||
                        ((EARLY_EXIT != 0) && (core_decided || diff_now))) begin
                        res_d       = res_now;
                        bits_used_d = consumed_now;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_q       <= 3'b000;
            bits_used_q <= '0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_q       <= res_d;
            bits_used_q <= bits_used_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign L         = res_q[2];
    assign E         = res_q[1];
    assign G         = res_q[0];
    assign bits_used = bits_used_q;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Scoreboard bench for serial_compare_sequencer: three instances
// (WIDTH=8 early exit, WIDTH=8 full scan, WIDTH=1) driven by directed vectors.
module tb_serial_compare_sequencer;

    typedef struct {
        logic [2:0] res;
        int         bits;
        int         done_cyc;
    } item_t;

    localparam logic [2:0] XL = 3'b100;
    localparam logic [2:0] XE = 3'b010;
    localparam logic [2:0] XG = 3'b001;

    logic       clk;
    logic       rst;
    logic       abort;
    logic       start_v [3];
    logic [7:0] a_v     [3];
    logic [7:0] b_v     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       l_v     [3];
    logic       e_v     [3];
    logic       g_v     [3];
    logic [3:0] bu0;
    logic [3:0] bu1;
    logic [0:0] bu2;

    item_t exp_q0[$];
    item_t exp_q1[$];
    item_t exp_q2[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Device under test: early-exit WIDTH=8
    serial_compare_sequencer #(.WIDTH(8), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort),
        .a_in(a_v[0]), .b_in(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .L(l_v[0]), .E(e_v[0]), .G(g_v[0]), .bits_used(bu0)
    );

    // Full-scan WIDTH=8 instance
    serial_compare_sequencer #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort),
        .a_in(a_v[1]), .b_in(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .L(l_v[1]), .E(e_v[1]), .G(g_v[1]), .bits_used(bu1)
    );

    // Single-bit instance
    serial_compare_sequencer #(.WIDTH(1), .EARLY_EXIT(1)) dut_w1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort),
        .a_in(a_v[2][0:0]), .b_in(b_v[2][0:0]), .busy(busy_v[2]), .done(done_v[2]),
        .L(l_v[2]), .E(e_v[2]), .G(g_v[2]), .bits_used(bu2)
    );

    // Free-running clock and edge counter used for latency bookkeeping
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so a stuck run still ends with a visible failure
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int buOf(input int i);
        if (i == 0) return int'(bu0);
        if (i == 1) return int'(bu1);
        return int'(bu2);
    endfunction

    function automatic logic [2:0] legOf(input int i);
        return {l_v[i], e_v[i], g_v[i]};
    endfunction

    // Generic compare used by every check in the bench
    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Pops the expected result for instance i and compares it with the DUT
    task automatic checkOutput(input int i);
        item_t exp;
        int    n;
        case (i)
            0:       n = exp_q0.size();
            1:       n = exp_q1.size();
            default: n = exp_q2.size();
        endcase
        if (n == 0) begin
            check($sformatf("unexpected_done%0d", i), 1, 0);
        end else begin
            case (i)
                0:       exp = exp_q0.pop_front();
                1:       exp = exp_q1.pop_front();
                default: exp = exp_q2.pop_front();
            endcase
            check($sformatf("leg%0d", i), int'(legOf(i)), int'(exp.res));
            check($sformatf("bits_used%0d", i), buOf(i), exp.bits);
            check($sformatf("done_cycle%0d", i), cyc, exp.done_cyc);
            check($sformatf("busy_in_done%0d", i), int'(busy_v[i]), 0);
        end
    endtask

    // Monitor: on every falling edge, any done pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) checkOutput(i);
            end
        end
    end

    task automatic pushExp(input int i, input logic [2:0] res, input int bits, input int done_cyc);
        item_t it;
        it.res      = res;
        it.bits     = bits;
        it.done_cyc = done_cyc;
        case (i)
            0:       exp_q0.push_back(it);
            1:       exp_q1.push_back(it);
            default: exp_q2.push_back(it);
        endcase
    endtask

    // Issues one start with operands and queues the expected result
    task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] res, input int bits);
        @(negedge clk);
        start_v[i] = 1'b1;
        a_v[i]     = a;
        b_v[i]     = b;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        pushExp(i, res, bits, cyc + bits);
    endtask

    // Waits (bounded) until instance i is idle with no done pending
    task automatic waitIdle(input int i, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_v[i] || done_v[i]) && n < budget);
        check($sformatf("idle_timeout%0d", i), int'(n >= budget), 0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, int'(busy_v[0]), 0);
        check({tag, "_done"}, int'(done_v[0]), 0);
        check({tag, "_leg"}, int'(legOf(0)), 0);
        check({tag, "_bits_used"}, buOf(0), 0);
    endtask

    // Main directed sequence
    initial begin
        rst   = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Equal operands use every bit
        applyStimulus(0, 8'h5A, 8'h5A, XE, 8);
        waitIdle(0, 20);

        // MSB already decides
        applyStimulus(0, 8'h80, 8'h7F, XG, 1);
        waitIdle(0, 20);

        // LSB decides; stray starts during busy must be ignored and results held
        applyStimulus(0, 8'h12, 8'h13, XL, 8);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start_v[0] = 1'b1;
            a_v[0]     = 8'hFF;
            b_v[0]     = 8'h00;
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
            check("hold_leg", int'(legOf(0)), int'(XG));
            check("hold_bits_used", buOf(0), 1);
        end
        waitIdle(0, 20);

        // Back-to-back with start held high: second op accepted in the DONE cycle
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'd3;
        b_v[0]     = 8'd9;
        @(posedge clk);
        #1;
        pushExp(0, XL, 5, cyc + 5);
        pushExp(0, XG, 5, cyc + 11);
        a_v[0] = 8'd9;
        b_v[0] = 8'd3;
        repeat (6) @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("b2b_second_busy", int'(busy_v[0]), 1);
        waitIdle(0, 20);

        // Abort on the third shift cycle: no done, prior result kept
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'd1;
        b_v[0]     = 8'd0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", int'(busy_v[0]), 0);
        check("abort_leg", int'(legOf(0)), int'(XG));
        check("abort_bits_used", buOf(0), 5);
        repeat (10) @(posedge clk);
        applyStimulus(0, 8'd1, 8'd0, XG, 8);
        waitIdle(0, 20);

        // Asynchronous reset between edges in the middle of a compare
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'hFF;
        b_v[0]     = 8'hFF;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, XE, 8);
        waitIdle(0, 20);

        // Full-scan instance always consumes all bits
        applyStimulus(1, 8'h80, 8'h7F, XG, 8);
        waitIdle(1, 20);
        applyStimulus(1, 8'h12, 8'h13, XL, 8);
        waitIdle(1, 20);

        // Single-bit instance finishes one edge after start
        applyStimulus(2, 8'h01, 8'h00, XG, 1);
        waitIdle(2, 10);
        applyStimulus(2, 8'h00, 8'h01, XL, 1);
        waitIdle(2, 10);
        applyStimulus(2, 8'h01, 8'h01, XE, 1);
        waitIdle(2, 10);

        repeat (3) @(posedge clk);
        check("leftover_q0", exp_q0.size(), 0);
        check("leftover_q1", exp_q1.size(), 0);
        check("leftover_q2", exp_q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
